apb_master_nslave: RTL and testbench
====================================

// Module: apb_master_nslave
// PURPOSE
//  Parametrised APB3 requester (bridge) driving NUM_SLV completers from a simple
//  transfer/READ_WRITE request port, as used by the 2-slave APB environment.
//  Generalises that interface in three ways: N slaves via address decode,
//  pready wait states with an optional timeout, and pslverr/decode-error reporting.
//  Also supports back-to-back transfers without an IDLE cycle. Sits between the
//  test/CPU-side request port and the slave array.
// PARAMETERS
//  AW       32  address width (bits)
//  DW       32  data width (bits)
//  NUM_SLV  2   number of completers, >=1
//  SEL_W    $clog2(NUM_SLV) (min 1)  slave index = paddr[AW-1 -: SEL_W]
//  TIMEOUT  16  max ACCESS wait cycles before forced error; 0 = no timeout
// PORTS
//  pclk               in   1            clock, rising edge
//  presetn            in   1            async active-low reset
//  transfer           in   1            request valid
//  READ_WRITE         in   1            1 = read, 0 = write
//  apb_write_paddr    in   AW           write address
//  apb_write_data     in   DW           write data
//  apb_read_paddr     in   AW           read address
//  req_ready          out  1            request accepted this cycle when transfer=1
//  apb_read_data_out  out  DW           captured read data
//  xfer_done          out  1            1-cycle completion pulse
//  xfer_err           out  1            valid with xfer_done: pslverr | timeout | decode error
//  psel               out  NUM_SLV      one-hot select
//  penable            out  1            ACCESS phase
//  pwrite             out  1            1 = write
//  paddr              out  AW           address
//  pwdata             out  DW           write data
//  prdata             in   NUM_SLV*DW   slave i at [i*DW +: DW]
//  pready             in   NUM_SLV      per-slave ready
//  pslverr            in   NUM_SLV      per-slave error
// BEHAVIOUR
//  - One clock (pclk). Reset is asynchronous and active-low (presetn).
//    Reset clears all outputs and state to 0 (state = IDLE).
//  - Reset mid-transfer: psel/penable drop immediately. No done pulse. The
//    request is lost.
//  - FSM states: IDLE, SETUP, ACCESS.
//  - req_ready = (IDLE) | (ACCESS & completion).
//  - Accept = transfer & req_ready. On accept, latch:
//      pwrite = ~READ_WRITE
//      paddr  = READ_WRITE ? apb_read_paddr : apb_write_paddr
//      pwdata = apb_write_data
//      idx    = paddr decode
//  - IDLE --accept, idx<NUM_SLV--> SETUP: psel[idx]=1, penable=0.
//  - IDLE --accept, idx>=NUM_SLV--> IDLE: no psel. Next cycle xfer_done=1 and
//    xfer_err=1. Read data unchanged.
//  - SETUP --> ACCESS unconditionally: penable=1. paddr/pwrite/pwdata/psel are
//    stable from SETUP through the end of ACCESS.
//  - ACCESS: completion when pready[idx]=1, or when wait count == TIMEOUT
//    (TIMEOUT != 0). Wait count resets on entering SETUP.
//  - On the completion edge:
//      penable <= 0
//      if read and pready: apb_read_data_out <= prdata[idx]
//      xfer_done <= 1 (1 cycle)
//      xfer_err  <= pslverr[idx] | timeout
//  - Next state after completion: SETUP if accept in the same cycle
//    (back-to-back; psel may switch slave), else IDLE with psel = 0.
//  - Latency, zero-wait slave: accept at edge N, SETUP N+1, ACCESS N+2, done
//    visible N+3.
//  - pslverr is ignored unless pready=1. Unselected slaves' pready/pslverr/prdata
//    are ignored.
//  - Read data is held until the next successful read. A timed-out read does not
//    update it.
// STRUCTURE
//  - apb_pkg holds:
//      typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
//      default AW/DW localparams
//      function to compute SEL_W
//  - Sub-module apb_addr_decode (paddr -> idx, one-hot sel, valid). Purely
//    combinational.
//  - FSM, latch registers and timeout counter stay in apb_master_nslave.
// TESTING
//  1 Write A=0x0000_0010, D=0xDEAD_BEEF, slave0 pready=1 -> psel=01 SETUP then
//    ACCESS; done after 3 cycles, err=0.
//  2 Read A=0x8000_0004 (slave1) with pready low for 2 cycles, prdata=0x1234_5678
//    -> penable held 3 cycles; read_data_out=0x1234_5678; done 1 cycle, err=0.
//  3 Two writes with transfer held high across completion -> no IDLE between;
//    2nd SETUP immediately after 1st ACCESS; exactly 2 done pulses.
//  4 pslverr=1 with pready=1 on read -> done & err=1. TIMEOUT=4, pready stuck 0
//    -> err after 4 wait cycles; read data unchanged.
//  5 NUM_SLV=3, address index 3 -> no psel asserted; done & err next cycle.
//  6 presetn low during ACCESS -> psel/penable=0 at once; no done; a new transfer
//    after reset completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type, default bus widths and select-width helper
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps the address select field to a slave index, one-hot select and valid flag
module apb_addr_decode #(
  parameter int NUM_SLV = 2,
  parameter int SEL_W = 1
) (
  input  logic [SEL_W-1:0]   sel_bits,
  output logic [SEL_W-1:0]   idx,
  output logic [NUM_SLV-1:0] sel,
  output logic               valid
);
  always_comb begin
    idx = sel_bits;
    valid = 32'(sel_bits) < NUM_SLV;
    sel = valid ? NUM_SLV'(1) << sel_bits : '0;
  end
endmodule

// File: rtl/apb_master_nslave.sv
// apb_master_nslave: APB3 requester for NUM_SLV completers with wait-state timeout,
// error reporting and back-to-back transfers
module apb_master_nslave
  import apb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int NUM_SLV = 2,
  parameter int SEL_W = sel_w(NUM_SLV),
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [AW-1:0]         apb_write_paddr,
  input  logic [DW-1:0]         apb_write_data,
  input  logic [AW-1:0]         apb_read_paddr,
  output logic                  req_ready,
  output logic [DW-1:0]         apb_read_data_out,
  output logic                  xfer_done,
  output logic                  xfer_err,
  output logic [NUM_SLV-1:0]    psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  input  logic [NUM_SLV*DW-1:0] prdata,
  input  logic [NUM_SLV-1:0]    pready,
  input  logic [NUM_SLV-1:0]    pslverr
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  apb_state_e state, state_nx;
  logic [SEL_W-1:0] idx, dec_idx;
  logic [NUM_SLV-1:0] dec_sel;
  logic [CW-1:0] cnt;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] sel_rdata;
  logic dec_ok, dec_pend, accept, complete, timed_out, dec_fire, sel_ready, sel_err;
  apb_addr_decode #(.NUM_SLV(NUM_SLV), .SEL_W(SEL_W)) u_dec (
    .sel_bits(req_addr[AW-1 -: SEL_W]),
    .idx(dec_idx),
    .sel(dec_sel),
    .valid(dec_ok)
  );
  always_comb begin
    req_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
    sel_ready = pready[idx];
    sel_err = pslverr[idx];
    sel_rdata = prdata[32'(idx)*DW +: DW];
    timed_out = TIMEOUT != 0 && cnt == CW'(TIMEOUT) && !sel_ready;
    complete = state == ACCESS && (sel_ready || timed_out);
    req_ready = state == IDLE || complete;
    accept = transfer && req_ready;
    dec_fire = state == IDLE && (dec_pend || (accept && !dec_ok));
    state_nx = accept && dec_ok ? SETUP : state == SETUP || (state == ACCESS && !complete) ? ACCESS : IDLE;
  end
  // a bad address accepted on a completion edge reports its error one cycle later via dec_pend
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      dec_pend <= 1'b0;
      psel <= '0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      apb_read_data_out <= '0;
      xfer_done <= 1'b0;
      xfer_err <= 1'b0;
    end else begin
      state <= state_nx;
      penable <= state_nx == ACCESS;
      psel <= accept ? dec_sel : state_nx == IDLE ? '0 : psel;
      cnt <= state == ACCESS && !complete ? cnt + 1'b1 : '0;
      dec_pend <= accept && !dec_ok && (state == ACCESS || dec_pend);
      xfer_done <= complete || dec_fire;
      xfer_err <= complete ? !sel_ready || sel_err : dec_fire;
      if (accept) begin
        pwrite <= ~READ_WRITE;
        paddr <= req_addr;
        pwdata <= apb_write_data;
      end
      if (accept && dec_ok) idx <= dec_idx;
      if (complete && sel_ready && !pwrite) apb_read_data_out <= sel_rdata;
    end
  end
endmodule

// File: tb/tb_apb_master_nslave.sv
// tb_apb_master_nslave: table-driven and randomized transfers against a transaction-level model,
// plus back-to-back and reset-during-ACCESS sequences (3 slaves, TIMEOUT=4)
module tb_apb_master_nslave;
  localparam int NSLV = 3;
  localparam int TOUT = 4;
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        slverr;
    logic        err;
    logic [31:0] rd;
    int          pen;
  } xfer_t;
  logic clk = 0, presetn = 0, transfer = 0, READ_WRITE = 0;
  logic [31:0] apb_write_paddr = 0, apb_write_data = 0, apb_read_paddr = 0;
  logic req_ready, xfer_done, xfer_err, penable, pwrite;
  logic [31:0] apb_read_data_out, paddr, pwdata;
  logic [2:0] psel;
  logic [95:0] prdata = '0;
  logic [2:0] pready = '0, pslverr = '0;
  int n_chk = 0, n_fail = 0, dn = 0;
  logic [31:0] model_rd = 0;
  xfer_t tbl[8];
  xfer_t t;

  apb_master_nslave #(.NUM_SLV(NSLV), .TIMEOUT(TOUT)) dut (
    .pclk(clk), .presetn(presetn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .req_ready(req_ready),
    .apb_read_data_out(apb_read_data_out), .xfer_done(xfer_done), .xfer_err(xfer_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic noise();
    pready = 3'($urandom);
    pslverr = 3'($urandom);
    for (int i = 0; i < NSLV; i++) prdata[i*32 +: 32] = $urandom;
  endtask

  task automatic model(inout xfer_t x);
    int ix;
    ix = int'(x.addr[31:30]);
    if (ix >= NSLV) begin
      x.err = 1'b1;
      x.pen = 0;
    end else if (x.waits > TOUT) begin
      x.err = 1'b1;
      x.pen = TOUT + 1;
    end else begin
      x.err = x.slverr;
      x.pen = x.waits + 1;
      if (x.rw) model_rd = x.rdata;
    end
    x.rd = model_rd;
  endtask

  task automatic do_xfer(input xfer_t x);
    int ix, pen;
    logic [2:0] es;
    ix = int'(x.addr[31:30]);
    es = 3'b001 << ix;
    pen = 0;
    @(negedge clk);
    chk("req_ready_idle", {63'b0, req_ready}, 1);
    noise();
    transfer = 1;
    READ_WRITE = x.rw;
    apb_read_paddr = x.rw ? x.addr : $urandom;
    apb_write_paddr = x.rw ? $urandom : x.addr;
    apb_write_data = x.wdata;
    @(negedge clk);
    transfer = 0;
    if (x.pen == 0) begin
      chk("dec_psel", {61'b0, psel}, 0);
      chk("dec_penable", {63'b0, penable}, 0);
      chk("dec_done", {63'b0, xfer_done}, 1);
      chk("dec_err", {63'b0, xfer_err}, 1);
      chk("dec_rd", {32'b0, apb_read_data_out}, {32'b0, x.rd});
    end else begin
      chk("setup_psel", {61'b0, psel}, {61'b0, es});
      chk("setup_penable", {63'b0, penable}, 0);
      chk("setup_paddr", {32'b0, paddr}, {32'b0, x.addr});
      chk("setup_pwrite", {63'b0, pwrite}, {63'b0, ~x.rw});
      chk("setup_pwdata", {32'b0, pwdata}, {32'b0, x.wdata});
      chk("setup_done", {63'b0, xfer_done}, 0);
      noise();
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (!penable) break;
        pen++;
        chk("access_psel", {61'b0, psel}, {61'b0, es});
        chk("access_paddr", {32'b0, paddr}, {32'b0, x.addr});
        noise();
        pready[ix] = (k == x.waits);
        if (k == x.waits) begin
          pslverr[ix] = x.slverr;
          prdata[ix*32 +: 32] = x.rdata;
        end
      end
      chk("penable_cycles", 64'(pen), 64'(x.pen));
      chk("done", {63'b0, xfer_done}, 1);
      chk("err", {63'b0, xfer_err}, {63'b0, x.err});
      chk("rd_data", {32'b0, apb_read_data_out}, {32'b0, x.rd});
      chk("idle_psel", {61'b0, psel}, 0);
    end
    @(negedge clk);
    chk("done_pulse_end", {63'b0, xfer_done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1};
    tbl[1] = '{1'b1, 32'h8000_0004, 32'h0, 32'h1234_5678, 2, 1'b0, 1'b0, 32'h1234_5678, 3};
    tbl[2] = '{1'b1, 32'h4000_0008, 32'h0, 32'hAAAA_5555, 0, 1'b1, 1'b1, 32'hAAAA_5555, 1};
    tbl[3] = '{1'b1, 32'h4000_0000, 32'h0, 32'h1111_1111, 9, 1'b0, 1'b1, 32'hAAAA_5555, 5};
    tbl[4] = '{1'b0, 32'hC000_0000, 32'h5A5A_5A5A, 32'h0, 0, 1'b0, 1'b1, 32'hAAAA_5555, 0};
    tbl[5] = '{1'b1, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 4, 1'b0, 1'b0, 32'hCAFE_F00D, 5};
    tbl[6] = '{1'b0, 32'h4000_0040, 32'h0BAD_F00D, 32'h0, 1, 1'b1, 1'b1, 32'hCAFE_F00D, 2};
    tbl[7] = '{1'b1, 32'hC000_0004, 32'h0, 32'h7777_7777, 0, 1'b0, 1'b1, 32'hCAFE_F00D, 0};
    repeat (3) @(negedge clk);
    chk("rst_psel", {61'b0, psel}, 0);
    chk("rst_penable", {63'b0, penable}, 0);
    chk("rst_done", {63'b0, xfer_done}, 0);
    chk("rst_err", {63'b0, xfer_err}, 0);
    chk("rst_rd", {32'b0, apb_read_data_out}, 0);
    chk("rst_paddr", {32'b0, paddr}, 0);
    chk("rst_req_ready", {63'b0, req_ready}, 1);
    presetn = 1;
    for (int i = 0; i < 8; i++) do_xfer(tbl[i]);
    // back-to-back writes: transfer stays high across the first completion
    @(negedge clk);
    dn = 0;
    pready = '0;
    pslverr = '0;
    transfer = 1;
    READ_WRITE = 0;
    apb_write_paddr = 32'h0000_0100;
    apb_write_data = 32'h1111_2222;
    @(negedge clk);
    dn += int'(xfer_done);
    chk("b2b_setup1_psel", {61'b0, psel}, 1);
    apb_write_paddr = 32'h4000_0200;
    apb_write_data = 32'h3333_4444;
    pready = 3'b001;
    @(negedge clk);
    dn += int'(xfer_done);
    chk("b2b_access1_penable", {63'b0, penable}, 1);
    chk("b2b_access1_pwdata", {32'b0, pwdata}, 64'h1111_2222);
    chk("b2b_access1_ready", {63'b0, req_ready}, 1);
    @(negedge clk);
    dn += int'(xfer_done);
    transfer = 0;
    chk("b2b_setup2_psel", {61'b0, psel}, 2);
    chk("b2b_setup2_penable", {63'b0, penable}, 0);
    chk("b2b_setup2_ready", {63'b0, req_ready}, 0);
    chk("b2b_setup2_paddr", {32'b0, paddr}, 64'h4000_0200);
    chk("b2b_setup2_pwdata", {32'b0, pwdata}, 64'h3333_4444);
    pready = 3'b010;
    @(negedge clk);
    dn += int'(xfer_done);
    chk("b2b_access2_penable", {63'b0, penable}, 1);
    @(negedge clk);
    dn += int'(xfer_done);
    chk("b2b_end_psel", {61'b0, psel}, 0);
    chk("b2b_end_err", {63'b0, xfer_err}, 0);
    @(negedge clk);
    dn += int'(xfer_done);
    chk("b2b_done_count", 64'(dn), 2);
    // reset asserted in the middle of an ACCESS phase
    pready = '0;
    transfer = 1;
    READ_WRITE = 1;
    apb_read_paddr = 32'h4000_0000;
    @(negedge clk);
    transfer = 0;
    @(negedge clk);
    chk("rstmid_penable_before", {63'b0, penable}, 1);
    #2 presetn = 0;
    #1;
    chk("rstmid_psel", {61'b0, psel}, 0);
    chk("rstmid_penable", {63'b0, penable}, 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      dn += int'(xfer_done);
    end
    presetn = 1;
    repeat (2) begin
      @(negedge clk);
      dn += int'(xfer_done);
    end
    chk("rstmid_no_done", 64'(dn), 0);
    chk("rstmid_rd", {32'b0, apb_read_data_out}, 0);
    do_xfer('{1'b1, 32'h4000_0010, 32'h0, 32'h600D_CAFE, 1, 1'b0, 1'b0, 32'h600D_CAFE, 2});
    model_rd = 32'h600D_CAFE;
    for (int i = 0; i < 60; i++) begin
      t.rw = 1'($urandom);
      t.addr = {2'($urandom_range(0, 3)), 30'($urandom)};
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.waits = $urandom_range(0, 6);
      t.slverr = 1'($urandom);
      model(t);
      do_xfer(t);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
